crypto_engine: RTL and testbench
================================

Name: crypto_engine

Overview:
- Multi-cycle responder for the crypto-enable request that the execute-stage ALU raises on opcodes 25 (enc) and 26 (dec).
- Latches the 19-bit data and key operands and runs an iterative rotate/XOR cipher over ROUNDS rounds.
- Returns the result with a one-cycle done pulse and holds busy high for the whole operation.
- Decrypt is the exact inverse of encrypt for the same key.

Parameters:
- ROUNDS, 8, number of cipher rounds; legal range 1..16.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- crypto_en  input  1  request strobe from ALU; sampled only in IDLE
- opcode  input  5  5'b11001 = encrypt, 5'b11010 = decrypt; others illegal
- data_in  input  19  plaintext (enc) or ciphertext (dec); ALU operand_a
- key_in  input  19  initial key k0; ALU operand_b
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when result is updated
- result  output  19  last completed output; held until next completion
- err  output  1  one-cycle pulse for crypto_en with an illegal opcode

Behaviour:
- Reset (synchronous, active-high) forces state IDLE.
  - busy=0, done=0, err=0, result=0.
  - Internal x, k and round counter are cleared.
  - Reset mid-operation abandons the operation with no done pulse.
- Notation:
  - rotl3, rotr3, rotl5 and rotr5 are 19-bit circular rotations; bit 18 wraps to bit 0 and vice versa.
  - i is the round index, zero-extended to 19 bits.
- States: IDLE, EXPAND, ROUND.
- IDLE:
  - On crypto_en=1 with opcode 11001: x<=data_in, k<=key_in, i<=0, mode<=enc, goto ROUND, busy<=1.
  - On crypto_en=1 with opcode 11010: x<=data_in, k<=key_in, i<=0, mode<=dec, goto EXPAND, busy<=1.
  - On crypto_en=1 with any other opcode: err<=1 for one cycle, stay in IDLE, result unchanged.
- EXPAND (dec only), one edge per step, i = 0..ROUNDS-1:
  - k<=rotl5(k)^i, i<=i+1.
  - After the ROUNDS-th step: i<=ROUNDS-1, goto ROUND.
- ROUND, enc mode, i = 0..ROUNDS-1:
  - x<=rotl3(x^k), k<=rotl5(k)^i, i<=i+1.
- ROUND, dec mode, i = ROUNDS-1 down to 0:
  - Per edge, with ki = rotr5(k^i) computed combinationally in the same cycle: x<=rotr3(x)^ki, k<=ki, i<=i-1.
- Completion:
  - On the final round edge: result<=new x, done<=1, busy<=0, goto IDLE.
  - done is high for exactly one cycle.
- Latency, counted from the edge that accepts crypto_en to the edge that sets done:
  - Encrypt: ROUNDS edges.
  - Decrypt: 2*ROUNDS edges.
- Back-to-back:
  - crypto_en is accepted in the cycle where done=1, since the block is already in IDLE.
  - A new accept sets busy on that edge and clears done.
- crypto_en while busy=1 is ignored: no err, no queuing.
- Inputs are sampled only on the accept edge; later changes to data_in, key_in and opcode do not affect the operation.
- Round-trip property: for any data d, key k0 and ROUNDS value, dec(enc(d, k0), k0) = d.
- All arithmetic is 19-bit wrap; there is no carry or overflow.

Test Plan:
- Encrypt, ROUNDS=1, data=19'h00001, key=19'h00002 -> done exactly 1 edge after accept, result=19'h00018, busy low during done.
- Decrypt, ROUNDS=1, data=19'h00018, key=19'h00002 -> done 2 edges after accept, result=19'h00001.
- Encrypt wrap, ROUNDS=1, data=19'h40000, key=0 -> result=19'h00004, confirming bit 18 rotates into bit 2.
- Round trip, ROUNDS=8, random data/key x1000: encrypt then decrypt with the same key -> decrypt result equals the original data.
  - Encrypt done latency is 8 edges; decrypt is 16.
  - data_in and key_in are toggled mid-operation, with no effect on the result.
- crypto_en with opcode 5'b00000 in IDLE -> err pulses 1 cycle, busy stays 0, result unchanged.
  - crypto_en pulsed while busy -> ignored, single done pulse.
- rst asserted mid-decrypt at EXPAND step 3 -> next cycle busy=0, done=0, result=0, no done pulse.
  - A fresh encrypt issued the cycle after reset deasserts completes normally.

Source files
------------

// File: rtl/crypto_if.sv
// ----------------------------------------------------------------------------
// crypto_if
// Request/response bundle between the execute-stage ALU and crypto_engine.
//   crypto_en : request strobe from the ALU (sampled only while idle)
//   opcode    : 5'b11001 encrypt, 5'b11010 decrypt, anything else is illegal
//   data_in   : 19-bit plaintext (enc) or ciphertext (dec), ALU operand_a
//   key_in    : 19-bit initial key k0, ALU operand_b
//   busy      : high while an operation is in progress
//   done      : one-cycle pulse when result is updated
//   result    : last completed output, held until the next completion
//   err       : one-cycle pulse for a request carrying an illegal opcode
// master = ALU side, slave = crypto_engine side.
// ----------------------------------------------------------------------------
interface crypto_if;
  logic        crypto_en;
  logic [4:0]  opcode;
  logic [18:0] data_in;
  logic [18:0] key_in;
  logic        busy;
  logic        done;
  logic [18:0] result;
  logic        err;

  modport master (
    output crypto_en, opcode, data_in, key_in,
    input  busy, done, result, err
  );

  modport slave (
    input  crypto_en, opcode, data_in, key_in,
    output busy, done, result, err
  );
endinterface

// File: rtl/crypto_engine.sv
// ----------------------------------------------------------------------------
// crypto_engine
// Multi-cycle rotate/XOR cipher on 19-bit operands, raised by the ALU for
// opcodes 25 (enc) and 26 (dec). Encrypt runs ROUNDS round edges; decrypt
// first replays the key schedule forward (EXPAND, ROUNDS edges) and then
// unwinds the rounds backwards, so decrypt is the exact inverse of encrypt.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset
//   bus : crypto_if.slave (request in, busy/done/result/err out)
// Parameter:
//   ROUNDS : number of cipher rounds, legal range 1..16
// ----------------------------------------------------------------------------
module crypto_engine #(
  parameter int unsigned ROUNDS = 8
) (
  input  logic     clk,
  input  logic     rst,
  crypto_if.slave  bus
);

  localparam logic [4:0] OP_ENC = 5'b11001;
  localparam logic [4:0] OP_DEC = 5'b11010;
  // Round counter is 5 bits so ROUNDS=16 still fits the last index (15).
  localparam logic [4:0] LAST   = 5'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    ROUND
  } state_e;

  state_e      state_q;
  logic        dec_q;      // 1 = decrypt mode, 0 = encrypt mode
  logic [18:0] x_q;
  logic [18:0] k_q;
  logic [4:0]  i_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [18:0] result_q;

  function automatic logic [18:0] rotl(input logic [18:0] v, input int unsigned n);
    return (v << n) | (v >> (19 - n));
  endfunction

  function automatic logic [18:0] rotr(input logic [18:0] v, input int unsigned n);
    return (v >> n) | (v << (19 - n));
  endfunction

  // Per-round next values, shared by the single FSM process below.
  logic [18:0] i_ext;
  logic [18:0] k_fwd_d;   // forward key step: used by encrypt rounds and EXPAND
  logic [18:0] ki_dec_d;  // backward key step: recovers the key of round i
  logic [18:0] x_enc_d;
  logic [18:0] x_dec_d;

  assign i_ext    = {14'd0, i_q};
  assign k_fwd_d  = rotl(k_q, 5) ^ i_ext;
  assign ki_dec_d = rotr(k_q ^ i_ext, 5);
  assign x_enc_d  = rotl(x_q ^ k_q, 3);
  assign x_dec_d  = rotr(x_q, 3) ^ ki_dec_d;

  // NOTE: every register here is written with <= so all updates in one edge
  // see the pre-edge values (x and k of the same round use the old k).
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: these are plain flops, not a memory array, so all of them are
      // reset; a reset mid-operation therefore leaves no stale round state.
      state_q  <= IDLE;
      dec_q    <= 1'b0;
      x_q      <= '0;
      k_q      <= '0;
      i_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      // done and err are single-cycle pulses unless re-raised below.
      done_q <= 1'b0;
      err_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.crypto_en) begin
            if (bus.opcode == OP_ENC || bus.opcode == OP_DEC) begin
              x_q     <= bus.data_in;
              k_q     <= bus.key_in;
              i_q     <= '0;
              dec_q   <= (bus.opcode == OP_DEC);
              busy_q  <= 1'b1;
              state_q <= (bus.opcode == OP_DEC) ? EXPAND : ROUND;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        EXPAND: begin
          // Walk the key schedule forward to k_ROUNDS so ROUND can unwind it.
          k_q <= k_fwd_d;
          if (i_q == LAST) begin
            i_q     <= LAST;
            state_q <= ROUND;
          end else begin
            i_q <= i_q + 5'd1;
          end
        end

        ROUND: begin
          if (!dec_q) begin
            x_q <= x_enc_d;
            k_q <= k_fwd_d;
            i_q <= i_q + 5'd1;
            if (i_q == LAST) begin
              result_q <= x_enc_d;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              i_q      <= '0;
              state_q  <= IDLE;
            end
          end else begin
            x_q <= x_dec_d;
            k_q <= ki_dec_d;
            i_q <= i_q - 5'd1;
            if (i_q == 5'd0) begin
              result_q <= x_dec_d;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              i_q      <= '0;
              state_q  <= IDLE;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_crypto_engine.sv
// ----------------------------------------------------------------------------
// tb_crypto_engine
// Drives two engines (ROUNDS=1 and ROUNDS=8) through directed and random
// encrypt/decrypt requests and compares against a plain-arithmetic cipher
// model. Inputs change on the falling edge; outputs are read 1ns after the
// rising edge.
// ----------------------------------------------------------------------------
module tb_crypto_engine;

  localparam logic [4:0] OP_ENC = 5'b11001;
  localparam logic [4:0] OP_DEC = 5'b11010;
  localparam bit         S1     = 1'b0;   // selects the ROUNDS=1 engine
  localparam bit         S8     = 1'b1;   // selects the ROUNDS=8 engine

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  crypto_if bus1 ();
  crypto_if bus8 ();

  crypto_engine #(.ROUNDS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  crypto_engine #(.ROUNDS(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [18:0] m_rotl(input logic [18:0] v, input int n);
    logic [37:0] w;
    w = {v, v} << n;
    return w[37:19];
  endfunction

  // Encrypt straight from the round rules: x = rotl3(x^k), k = rotl5(k)^i.
  function automatic logic [18:0] model_enc(input logic [18:0] d,
                                            input logic [18:0] k0,
                                            input int rounds);
    logic [18:0] x;
    logic [18:0] k;
    x = d;
    k = k0;
    for (int r = 0; r < rounds; r++) begin
      x = m_rotl(x ^ k, 3);
      k = m_rotl(k, 5) ^ 19'(r);
    end
    return x;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_busy(input bit s);
    return s ? bus8.busy : bus1.busy;
  endfunction
  function automatic logic get_done(input bit s);
    return s ? bus8.done : bus1.done;
  endfunction
  function automatic logic get_err(input bit s);
    return s ? bus8.err : bus1.err;
  endfunction
  function automatic logic [18:0] get_result(input bit s);
    return s ? bus8.result : bus1.result;
  endfunction

  task automatic drive(input bit s, input logic en, input logic [4:0] op,
                       input logic [18:0] d, input logic [18:0] k);
    if (s) begin
      bus8.crypto_en = en; bus8.opcode = op; bus8.data_in = d; bus8.key_in = k;
    end else begin
      bus1.crypto_en = en; bus1.opcode = op; bus1.data_in = d; bus1.key_in = k;
    end
  endtask

  // Present a request for exactly one rising edge; returns 1ns after it.
  task automatic issue(input bit s, input logic [4:0] op,
                       input logic [18:0] d, input logic [18:0] k);
    @(negedge clk);
    drive(s, 1'b1, op, d, k);
    @(posedge clk);
    #1;
    if (s) bus8.crypto_en = 1'b0;
    else   bus1.crypto_en = 1'b0;
  endtask

  // Accept an operation, scramble the operands while it runs, and wait
  // (bounded) for done. lat = edges from accept to the edge that set done.
  task automatic run(input bit s, input logic [4:0] op,
                     input logic [18:0] d, input logic [18:0] k,
                     input string tag,
                     output logic [18:0] res, output int lat);
    issue(s, op, d, k);
    check({tag, "_busy_on_accept"}, 32'(get_busy(s)), 32'd1);
    check({tag, "_done_clear_on_accept"}, 32'(get_done(s)), 32'd0);
    lat = 0;
    while (!get_done(s) && lat < 64) begin
      @(negedge clk);
      drive(s, 1'b0, 5'($urandom), 19'($urandom), 19'($urandom));
      @(posedge clk);
      #1;
      lat++;
    end
    res = get_result(s);
    check({tag, "_busy_low_at_done"}, 32'(get_busy(s)), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [18:0] res;
    logic [18:0] ct;
    logic [18:0] d;
    logic [18:0] k;
    logic [18:0] prev;
    int          lat;
    int          n_done;
    int          n_err;

    errors = 0;
    checks = 0;
    rst = 1'b1;
    drive(S1, 1'b0, 5'd0, 19'd0, 19'd0);
    drive(S8, 1'b0, 5'd0, 19'd0, 19'd0);

    // Reset state on both engines.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy1",   32'(bus1.busy),   32'd0);
    check("rst_done1",   32'(bus1.done),   32'd0);
    check("rst_err1",    32'(bus1.err),    32'd0);
    check("rst_result1", 32'(bus1.result), 32'd0);
    check("rst_busy8",   32'(bus8.busy),   32'd0);
    check("rst_done8",   32'(bus8.done),   32'd0);
    check("rst_err8",    32'(bus8.err),    32'd0);
    check("rst_result8", 32'(bus8.result), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ROUNDS=1 directed vectors.
    run(S1, OP_ENC, 19'h00001, 19'h00002, "enc1", res, lat);
    check("enc1_result", 32'(res), 32'h00018);
    check("enc1_latency", 32'(lat), 32'd1);
    @(posedge clk);
    #1;
    check("enc1_done_one_cycle", 32'(bus1.done), 32'd0);

    run(S1, OP_DEC, 19'h00018, 19'h00002, "dec1", res, lat);
    check("dec1_result", 32'(res), 32'h00001);
    check("dec1_latency", 32'(lat), 32'd2);

    // Back-to-back: issued in the done cycle of the previous decrypt.
    run(S1, OP_ENC, 19'h40000, 19'h00000, "encwrap", res, lat);
    check("encwrap_result", 32'(res), 32'h00004);
    check("encwrap_latency", 32'(lat), 32'd1);

    // ROUNDS=8 random round trips with back-to-back issue.
    for (int t = 0; t < 1000; t++) begin
      d = 19'($urandom);
      k = 19'($urandom);
      run(S8, OP_ENC, d, k, "rt_enc", ct, lat);
      check("rt_enc_result", 32'(ct), 32'(model_enc(d, k, 8)));
      check("rt_enc_latency", 32'(lat), 32'd8);
      run(S8, OP_DEC, ct, k, "rt_dec", res, lat);
      check("rt_dec_roundtrip", 32'(res), 32'(d));
      check("rt_dec_latency", 32'(lat), 32'd16);
    end
    prev = d;

    // Illegal opcode while idle.
    @(posedge clk);
    #1;
    issue(S8, 5'b00000, 19'h12345, 19'h0abcd);
    check("illegal_err_pulse", 32'(bus8.err), 32'd1);
    check("illegal_busy", 32'(bus8.busy), 32'd0);
    check("illegal_done", 32'(bus8.done), 32'd0);
    check("illegal_result_held", 32'(bus8.result), 32'(prev));
    @(posedge clk);
    #1;
    check("illegal_err_one_cycle", 32'(bus8.err), 32'd0);

    // Requests while busy are ignored: no err, one done, original result.
    d = 19'h2a5c3;
    k = 19'h71f0e;
    issue(S8, OP_ENC, d, k);
    n_done = 0;
    n_err  = 0;
    res    = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 1)      drive(S8, 1'b1, OP_DEC, 19'h11111, 19'h22222);
      else if (c == 2) drive(S8, 1'b1, 5'b00000, 19'h33333, 19'h44444);
      else             drive(S8, 1'b0, OP_ENC, 19'h55555, 19'h66666);
      @(posedge clk);
      #1;
      if (bus8.done) begin
        n_done++;
        res = bus8.result;
      end
      if (bus8.err) n_err++;
    end
    drive(S8, 1'b0, 5'd0, 19'd0, 19'd0);
    check("busy_ignore_done_count", 32'(n_done), 32'd1);
    check("busy_ignore_err_count", 32'(n_err), 32'd0);
    check("busy_ignore_result", 32'(res), 32'(model_enc(d, k, 8)));
    check("busy_ignore_idle", 32'(bus8.busy), 32'd0);

    // Reset during decrypt key expansion (step 3), then a fresh encrypt.
    issue(S8, OP_DEC, 19'h0beef, 19'h1cafe);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", 32'(bus8.busy), 32'd0);
    check("midrst_done", 32'(bus8.done), 32'd0);
    check("midrst_result", 32'(bus8.result), 32'd0);
    check("midrst_err", 32'(bus8.err), 32'd0);
    rst = 1'b0;
    d = 19'h6d2b9;
    k = 19'h03c47;
    run(S8, OP_ENC, d, k, "postrst", res, lat);
    check("postrst_result", 32'(res), 32'(model_enc(d, k, 8)));
    check("postrst_latency", 32'(lat), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
